// File: rtl/intra_recon_adder.sv
// intra_recon_adder
//   Reconstruction stage that follows control_directional_mode. It accepts one
//   4x4 intra prediction block and its 4x4 inverse-transform residual, and forms
//   clip(pred + res, 0, 2^BIT_DEPTH-1) for every sample. The result is sent out
//   one row per cycle under a valid/ready handshake, tagged with the block
//   position, for the frame/edge buffer writer.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   in_valid        pred/residual/x/y/skip carry one block
//   in_ready        block accepted when in_valid && in_ready (high only when idle)
//   skip            residual is treated as all zero
//   x, y            block position in samples
//   pred            [row][col] prediction, only bits [BIT_DEPTH-1:0] are used
//   residual        [row][col] signed residual
//   out_valid       recon_row carries a valid row
//   out_ready       row consumed when out_valid && out_ready
//   recon_row       reconstructed samples of row out_rownum, columns 0..3
//   out_rownum      row index 0..3
//   out_last        high together with row 3
//   out_x, out_y    position captured with the block being emitted
//   clip_count      number of clamped samples in the current block (0..16)
module intra_recon_adder #(
  parameter int BIT_DEPTH = 10,
  parameter int PRED_W    = 30,
  parameter int RES_W     = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 skip,
  input  logic [15:0]                          x,
  input  logic [15:0]                          y,
  input  logic [0:3][0:3][PRED_W-1:0]          pred,
  input  logic [0:3][0:3][RES_W-1:0]           residual,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [0:3][BIT_DEPTH-1:0]            recon_row,
  output logic [1:0]                           out_rownum,
  output logic                                 out_last,
  output logic [15:0]                          out_x,
  output logic [15:0]                          out_y,
  output logic [4:0]                           clip_count
);

  // Two guard bits above the wider operand keep the signed sum exact.
  localparam int SUM_W = ((BIT_DEPTH > RES_W) ? BIT_DEPTH : RES_W) + 2;
  localparam logic [SUM_W-1:0] MAX_SUM = {{(SUM_W-BIT_DEPTH){1'b0}}, {BIT_DEPTH{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                             state;
  logic [0:3][0:3][BIT_DEPTH-1:0]     cap_pred;
  logic [0:3][0:3][RES_W-1:0]         cap_res;
  logic [0:3][0:3][BIT_DEPTH-1:0]     recon_mem;
  logic [0:3][0:3][BIT_DEPTH-1:0]     clipped;
  logic [4:0]                         clip_total;
  logic [SUM_W-1:0]                   sum_tmp;
  logic                               pred_hi_unused;

  // The upper prediction bits carry no information for this stage.
  assign pred_hi_unused = ^pred;

  // Rows are read straight from the block registers; out_rownum only moves on a
  // handshake, so the data is stable while the consumer stalls.
  assign recon_row = recon_mem[out_rownum];

  // Clamp all 16 sums from the captured operands. The sign bit of the wide sum
  // marks an underflow; anything above MAX_SUM is an overflow.
  always_comb begin
    clipped    = '0;
    clip_total = '0;
    sum_tmp    = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sum_tmp = {{(SUM_W-BIT_DEPTH){1'b0}}, cap_pred[r][c]}
                + {{(SUM_W-RES_W){cap_res[r][c][RES_W-1]}}, cap_res[r][c]};
        if (sum_tmp[SUM_W-1]) begin
          clipped[r][c] = '0;
          clip_total    = clip_total + 5'd1;
        end else if (sum_tmp > MAX_SUM) begin
          clipped[r][c] = {BIT_DEPTH{1'b1}};
          clip_total    = clip_total + 5'd1;
        end else begin
          clipped[r][c] = sum_tmp[BIT_DEPTH-1:0];
        end
      end
    end
  end

  // Block FSM: capture in IDLE, register the clamped sums in SUM, then stream
  // four rows in EMIT. in_ready is registered and only high in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_rownum <= 2'd0;
      out_last   <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      clip_count <= '0;
      cap_pred   <= '0;
      cap_res    <= '0;
      recon_mem  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int r = 0; r < 4; r++) begin
              for (int c = 0; c < 4; c++) begin
                cap_pred[r][c] <= pred[r][c][BIT_DEPTH-1:0];
              end
            end
            cap_res    <= skip ? '0 : residual;
            out_x      <= x;
            out_y      <= y;
            clip_count <= '0;
            in_ready   <= 1'b0;
            state      <= SUM;
          end
        end
        SUM: begin
          recon_mem  <= clipped;
          clip_count <= clip_total;
          out_valid  <= 1'b1;
          out_rownum <= 2'd0;
          out_last   <= 1'b0;
          state      <= EMIT;
        end
        EMIT: begin
          if (out_ready) begin
            if (out_rownum == 2'd3) begin
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              out_rownum <= 2'd0;
              in_ready   <= 1'b1;
              state      <= IDLE;
            end else begin
              out_rownum <= out_rownum + 2'd1;
              out_last   <= (out_rownum == 2'd2);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
